// File: rtl/wb_commit_unit_pkg.sv
// wb_commit_unit_pkg: shared write-back types, FSM states and fixed register numbers
package wb_commit_unit_pkg;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {WB_RUN, WB_DRAIN, WB_HALTED} wb_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic jal;
        logic syscall_sig;
    } control_signal_t;

endpackage

// File: rtl/wb_commit_unit_data_mux.sv
// wb_data_mux: priority select of write-back data (link address > load data > ALU result)
module wb_data_mux #(
    parameter int DATA_W = 32
) (
    input  logic              jal,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] pc_plus8,
    output logic [DATA_W-1:0] data
);

    // jal link address beats load data, which beats the ALU result
    always_comb data = jal ? pc_plus8 : mem_to_reg ? mem_read_data : alu_res;

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: MEM/WB commit stage with register-file write, forwarding, retire count and halt FSM
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  control_signal_t   in_cs,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_read_data,
    input  logic [REG_AW-1:0] in_write_reg,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              halt_req,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    wb_state_e         state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              run_valid, we_nxt;
    logic [REG_AW-1:0] waddr_nxt;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  retired_nxt;

    assign run_valid = state == WB_RUN && in_valid;

    wb_data_mux #(.DATA_W(DATA_W)) u_data_mux (
        .jal           (in_cs.jal),
        .mem_to_reg    (in_cs.mem_to_reg),
        .alu_res       (in_alu_res),
        .mem_read_data (in_mem_read_data),
        .pc_plus8      (in_pc_plus8),
        .data          (sel_data)
    );

    // FSM state and drain countdown
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WB_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // committed syscall starts the drain; drain expiry parks the core in HALTED for good
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WB_RUN:   if (run_valid && in_cs.syscall_sig) begin
                          state_nxt = WB_DRAIN;
                          cnt_nxt   = 4'(DRAIN_CYCLES - 1);
                      end
            WB_DRAIN: if (cnt == '0) state_nxt = WB_HALTED;
                      else cnt_nxt = cnt - 4'd1;
            default:  state_nxt = state;
        endcase
    end

    // next values of the registered write port and retire counter; in_valid gates out don't-care flags
    always_comb begin
        waddr_nxt   = in_cs.jal ? REG_AW'(REG_RA) : in_write_reg;
        we_nxt      = run_valid && (in_cs.reg_write || in_cs.jal) && !in_cs.syscall_sig
                      && waddr_nxt != REG_AW'(REG_ZERO);
        retired_nxt = run_valid ? retired_count + CNT_W'(1) : retired_count;
    end

    // write port and retire counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            retired_count <= '0;
        end else begin
            rf_we         <= we_nxt;
            rf_waddr      <= waddr_nxt;
            rf_wdata      <= sel_data;
            retired_count <= retired_nxt;
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_reg   = rf_waddr;
    assign fwd_data  = rf_wdata;
    assign halt_req  = state != WB_RUN;
    assign halted    = state == WB_HALTED;

endmodule
